// File: rtl/riscv_enc_pkg.sv
// -----------------------------------------------------------------------------
// riscv_enc_pkg
// Shared types and constants for the RV32I instruction encoder.
//   imm_src_t   : immediate/format selector (I, S, B, J, U, R; 110/111 invalid)
//   OP_*        : base opcodes of the formats the boot loader emits
//   NOP_INST    : canonical addi x0,x0,0 used for unencodable requests
//   fits_signed : true when a 32-bit value survives truncation to 'bits' bits
//                 followed by sign extension
// -----------------------------------------------------------------------------
package riscv_enc_pkg;

    typedef enum logic [2:0] {
        SRC_I = 3'b000,
        SRC_S = 3'b001,
        SRC_B = 3'b010,
        SRC_J = 3'b011,
        SRC_U = 3'b100,
        SRC_R = 3'b101
    } imm_src_t;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Equivalent to "bits [31:bits-1] of v are all equal".
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic signed [31:0] w_ext;
        w_ext = $signed(v << (32 - bits)) >>> (32 - bits);
        return (w_ext == $signed(v));
    endfunction

endpackage

// File: rtl/imm_pack.sv
// -----------------------------------------------------------------------------
// imm_pack
// Combinational packer: scatters a byte-offset immediate and the register /
// function fields into a 32-bit RV32I word (inverse of decode immediate
// extraction).
// Optional feature macro: IMM_RANGE_CHECK_EN
//   defined   -> range_err flags immediates the selected format cannot hold
//                (the word is still built from the truncated bits)
//   undefined -> range_err is constant 0
// Ports:
//   imm_src  in  3   format select (see imm_src_t); 110/111 produce NOP_INST
//   imm      in  32  two's complement immediate
//   opcode, rd, rs1, rs2, funct3, funct7 in  standard instruction fields
//   inst     out 32  encoded word
//   range_err out 1  immediate unrepresentable (valid formats only)
// -----------------------------------------------------------------------------
module imm_pack
    import riscv_enc_pkg::*;
(
    input  logic [2:0]  imm_src,
    input  logic [31:0] imm,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    output logic [31:0] inst,
    output logic        range_err
);

    always_comb begin
        inst = NOP_INST;
        case (imm_src)
            SRC_I: inst = {imm[11:0], rs1, funct3, rd, opcode};
            SRC_S: inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            SRC_B: inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            SRC_J: inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            SRC_U: inst = {imm[31:12], rd, opcode};
            SRC_R: inst = {funct7, rs2, rs1, funct3, rd, opcode};
            default: inst = NOP_INST;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // B and J offsets are halfword multiples: a set bit 0 would be silently lost.
    always_comb begin
        range_err = 1'b0;
        case (imm_src)
            SRC_I, SRC_S: range_err = !fits_signed(imm, 12);
            SRC_B:        range_err = !fits_signed(imm, 13) || imm[0];
            SRC_J:        range_err = !fits_signed(imm, 21) || imm[0];
            SRC_U:        range_err = (imm[11:0] != 12'h000);
            default:      range_err = 1'b0;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

endmodule

// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder
// Builds RV32I instruction words for the UART boot loader and tags each with
// its instruction-memory byte address. One registered output stage with a
// valid/ready handshake; full throughput (no bubble on simultaneous
// hand-off and accept).
// Optional feature macro: IMM_RANGE_CHECK_EN (immediate range flagging, see
// imm_pack). Invalid imm_src is flagged in every build.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   clear            sync: out_addr <= BASE_ADDR, counters <= 0
//   in_valid/in_ready  field bundle handshake
//   imm_src, opcode, rd, rs1, rs2, funct3, funct7, imm   field bundle
//   out_valid/out_ready output word handshake
//   out_inst, out_addr, out_err   word, its byte address, error flag
//   word_count, err_count         saturating hand-off counters
// -----------------------------------------------------------------------------
module inst_encoder
    import riscv_enc_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        imm_src,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [CNT_W-1:0]  word_count,
    output logic [CNT_W-1:0]  err_count
);

    logic [31:0]       w_inst;
    logic              w_range_err;
    logic              w_src_err;
    logic              w_accept;
    logic              w_handoff;

    logic              r_valid;
    logic [31:0]       r_inst;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_word_cnt;
    logic [CNT_W-1:0]  r_err_cnt;

    imm_pack u_imm_pack (
        .imm_src   (imm_src),
        .imm       (imm),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .inst      (w_inst),
        .range_err (w_range_err)
    );

    assign w_src_err = (imm_src > SRC_R);
    assign in_ready  = !r_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_handoff = r_valid && out_ready;

    // Output word register. Loading only on accept keeps the word stable while
    // the consumer stalls, and an accept in the hand-off cycle refills with no gap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_inst  <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_inst  <= w_inst;
            r_err   <= w_src_err || w_range_err;
        end else if (w_handoff) begin
            r_valid <= 1'b0;
        end
    end

    // Address and counters advance on hand-off; clear takes priority so a
    // clear in a hand-off cycle leaves everything at its start value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr     <= BASE_ADDR;
            r_word_cnt <= '0;
            r_err_cnt  <= '0;
        end else if (clear) begin
            r_addr     <= BASE_ADDR;
            r_word_cnt <= '0;
            r_err_cnt  <= '0;
        end else if (w_handoff) begin
            r_addr <= r_addr + ADDR_W'(4);
            if (r_word_cnt != '1) begin
                r_word_cnt <= r_word_cnt + 1'b1;
            end
            if (r_err && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign out_valid  = r_valid;
    assign out_inst   = r_inst;
    assign out_addr   = r_addr;
    assign out_err    = r_err;
    assign word_count = r_word_cnt;
    assign err_count  = r_err_cnt;

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;
    import riscv_enc_pkg::*;

`ifdef IMM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, clear, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [2:0]  imm_src, funct3;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, out_inst, out_addr;
    logic [15:0] word_count, err_count;

    always #5 clk = ~clk;

    inst_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0000_0000), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .imm_src(imm_src), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err),
        .word_count(word_count), .err_count(err_count)
    );

    typedef struct {
        logic [2:0]  src;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp_inst;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    vec_t        vecs[12];
    exp_t        sb[$];
    exp_t        cur;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_addr = 32'h0;
    int          m_wc = 0;
    int          m_ec = 0;
    bit          acc_flag;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load(input int i);
        imm_src  = vecs[i].src;
        opcode   = vecs[i].op;
        rd       = vecs[i].rd;
        rs1      = vecs[i].rs1;
        rs2      = vecs[i].rs2;
        funct3   = vecs[i].f3;
        funct7   = vecs[i].f7;
        imm      = vecs[i].imm;
        cur.inst = vecs[i].exp_inst;
        cur.err  = vecs[i].exp_err;
        in_valid = 1'b1;
    endtask

    // One clock: evaluate both handshakes just before the edge, update the
    // scoreboard and the address/counter model, then advance past the edge.
    task automatic cycle();
        exp_t e;
        #1;
        acc_flag = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got inst %h with no word pending", out_inst);
            end else begin
                e = sb.pop_front();
                $display("word addr=%h inst=%h err=%0b", out_addr, out_inst, out_err);
                chk("out_inst", out_inst, e.inst);
                chk("out_err", {31'b0, out_err}, {31'b0, e.err});
                chk("out_addr", out_addr, m_addr);
            end
            m_addr = m_addr + 32'd4;
            if (m_wc < 65535) m_wc++;
            if (e.err && m_ec < 65535) m_ec++;
        end
        if (acc_flag) sb.push_back(cur);
        if (clear) begin
            m_addr = 32'h0;
            m_wc   = 0;
            m_ec   = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int i);
        load(i);
        acc_flag = 1'b0;
        for (int n = 0; n < 20; n++) begin
            cycle();
            if (acc_flag) break;
        end
        if (!acc_flag) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: vector %0d never accepted", i);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 30; n++) begin
            if (sb.size() == 0) break;
            cycle();
        end
        chk("drain_pending", sb.size(), 0);
    endtask

    initial begin
        //          src     op         rd     rs1    rs2    f3     f7      imm            exp_inst       exp_err
        vecs[0]  = '{3'b000, OP_IMM,    5'd1,  5'd0,  5'd0,  3'd0,  7'h00,  32'd5,         32'h0050_0093, 1'b0};
        vecs[1]  = '{3'b001, OP_STORE,  5'd0,  5'd2,  5'd5,  3'd2,  7'h00,  32'd8,         32'h0051_2423, 1'b0};
        vecs[2]  = '{3'b010, OP_BRANCH, 5'd0,  5'd0,  5'd0,  3'd0,  7'h00,  32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0};
        vecs[3]  = '{3'b011, OP_JAL,    5'd1,  5'd0,  5'd0,  3'd0,  7'h00,  32'd2048,      32'h0010_00EF, 1'b0};
        vecs[4]  = '{3'b100, OP_LUI,    5'd3,  5'd0,  5'd0,  3'd0,  7'h00,  32'h1234_5000, 32'h1234_51B7, 1'b0};
        vecs[5]  = '{3'b101, OP_REG,    5'd1,  5'd2,  5'd3,  3'd0,  7'h20,  32'hFFFF_FFFF, 32'h4031_00B3, 1'b0};
        vecs[6]  = '{3'b000, OP_IMM,    5'd1,  5'd0,  5'd0,  3'd0,  7'h00,  32'd4096,      32'h0000_0093, RC};
        vecs[7]  = '{3'b111, OP_IMM,    5'd1,  5'd2,  5'd3,  3'd1,  7'h00,  32'd5,         NOP_INST,      1'b1};
        vecs[8]  = '{3'b000, OP_IMM,    5'd2,  5'd2,  5'd0,  3'd0,  7'h00,  32'hFFFF_FFFF, 32'hFFF1_0113, 1'b0};
        vecs[9]  = '{3'b110, OP_LUI,    5'd4,  5'd0,  5'd0,  3'd0,  7'h00,  32'h0,         NOP_INST,      1'b1};
        vecs[10] = '{3'b010, OP_BRANCH, 5'd0,  5'd1,  5'd2,  3'd1,  7'h00,  32'd3,         32'h0020_9163, RC};
        vecs[11] = '{3'b100, OP_LUI,    5'd5,  5'd0,  5'd0,  3'd0,  7'h00,  32'h0000_1001, 32'h0000_12B7, RC};

        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        imm_src = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0;
        funct3 = '0; funct7 = '0; imm = '0;
        cur = '{32'h0, 1'b0};
        #12;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_inst", out_inst, 32'h0);
        chk("rst_out_addr", out_addr, 32'h0);
        chk("rst_out_err", {31'b0, out_err}, 32'd0);
        chk("rst_word_count", {16'b0, word_count}, 32'd0);
        chk("rst_err_count", {16'b0, err_count}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Table pass, consumer always ready: back-to-back words.
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) send(i);
        drain();
        chk("table_word_count", {16'b0, word_count}, 32'(m_wc));
        chk("table_err_count", {16'b0, err_count}, 32'(m_ec));
        chk("table_word_count_abs", {16'b0, word_count}, 32'd12);

        clear = 1'b1; cycle(); clear = 1'b0;
        chk("clear_addr", out_addr, 32'h0);
        chk("clear_word_count", {16'b0, word_count}, 32'd0);
        chk("clear_err_count", {16'b0, err_count}, 32'd0);

        // Backpressure: three words, consumer stalled for three cycles.
        out_ready = 1'b0;
        load(0); cycle();
        chk("bp_first_accept", {31'b0, acc_flag}, 32'd1);
        load(1);
        for (int k = 0; k < 3; k++) begin
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_hold_inst", out_inst, vecs[0].exp_inst);
            chk("bp_hold_addr", out_addr, 32'h0);
            chk("bp_hold_err", {31'b0, out_err}, 32'd0);
            cycle();
            chk("bp_no_accept", {31'b0, acc_flag}, 32'd0);
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_accept_on_handoff", {31'b0, acc_flag}, 32'd1);
        load(2); cycle();
        chk("bp_accept_third", {31'b0, acc_flag}, 32'd1);
        in_valid = 1'b0;
        chk("bp_no_bubble", {31'b0, out_valid}, 32'd1);
        drain();
        chk("bp_word_count", {16'b0, word_count}, 32'd3);
        chk("bp_addr_after", out_addr, 32'd12);
        clear = 1'b1; cycle(); clear = 1'b0;
        chk("bp_clear_addr", out_addr, 32'h0);
        chk("bp_clear_count", {16'b0, word_count}, 32'd0);

        // Clear while a word is pending, then clear coinciding with hand-off.
        out_ready = 1'b1;
        send(7); drain();
        chk("pre_clear_err_count", {16'b0, err_count}, 32'd1);
        out_ready = 1'b0;
        load(3); cycle(); in_valid = 1'b0;
        clear = 1'b1; cycle(); clear = 1'b0;
        chk("clear_keeps_valid", {31'b0, out_valid}, 32'd1);
        chk("clear_keeps_inst", out_inst, vecs[3].exp_inst);
        chk("clear_pending_err_count", {16'b0, err_count}, 32'd0);
        out_ready = 1'b1; clear = 1'b1; cycle(); clear = 1'b0;
        chk("clear_wins_count", {16'b0, word_count}, 32'd0);
        chk("clear_wins_addr", out_addr, 32'h0);
        chk("clear_wins_valid", {31'b0, out_valid}, 32'd0);

        // Reset in the middle of a transfer discards the pending word.
        out_ready = 1'b0;
        send(4);
        chk("mid_pending", {31'b0, out_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_reset_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_reset_inst", out_inst, 32'h0);
        sb.delete();
        m_addr = 32'h0; m_wc = 0; m_ec = 0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(5); drain();
        chk("post_reset_count", {16'b0, word_count}, 32'd1);
        chk("post_reset_addr", out_addr, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
